// File: rtl/adc_lane_deser.sv
`timescale 1ns/1ps
// adc_lane_deser
// Deserializes DDR rise/fall bit pairs from LANES data lanes and one frame lane
// into BITS-bit words. The word boundary is found by bit-slipping the
// extraction window until the frame lane shows FRAME_PATTERN for LOCK_CNT
// consecutive words. Once locked, aligned words for all lanes are emitted.
//
// Output strobe: word_valid is a one-cycle qualifier for word_data. There is
// no back-pressure; word_data is captured only on a word_valid cycle and is
// otherwise held.
module adc_lane_deser #(
    parameter int              LANES         = 8,
    parameter int              BITS          = 8,
    parameter logic [BITS-1:0] FRAME_PATTERN = 8'hF0,
    parameter int              LOCK_CNT      = 4,
    parameter int              UNLOCK_CNT    = 2
) (
    input  logic                      dco_clk,
    input  logic                      rst_n,
    input  logic [LANES-1:0]          bit_rise,
    input  logic [LANES-1:0]          bit_fall,
    input  logic                      frame_rise,
    input  logic                      frame_fall,
    input  logic                      resync,
    output logic [LANES*BITS-1:0]     word_data,
    output logic                      word_valid,
    output logic                      locked,
    output logic [$clog2(BITS)-1:0]   slip_pos,
    output logic                      frame_err,
    output logic [1:0]                dbg_state
);

    // History depth covers one full word plus every possible slip offset.
    localparam int HW      = 2 * BITS;
    localparam int SW      = $clog2(BITS);
    localparam int PH_LAST = BITS / 2 - 1;
    localparam int PH_W    = (BITS / 2 > 1) ? $clog2(BITS / 2) : 1;
    localparam int LC_W    = $clog2(LOCK_CNT + 1);
    localparam int UC_W    = $clog2(UNLOCK_CNT + 1);

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_SETTLE = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    // Shift histories, newest bit at the LSB.
    logic [LANES-1:0][HW-1:0] r_hist;
    logic [HW-1:0]            r_fhist;
    logic [PH_W-1:0]          r_ph;

    // Alignment state.
    state_t                   r_state;
    logic [SW-1:0]            r_slip;
    logic [LC_W-1:0]          r_match_cnt;
    logic [UC_W-1:0]          r_miss_cnt;

    // Registered outputs.
    logic [LANES*BITS-1:0]    r_word_data;
    logic                     r_word_valid;
    logic                     r_locked;
    logic                     r_frame_err;

    // Combinational helpers.
    logic [LANES-1:0][HW-1:0] w_hist_next;
    logic [HW-1:0]            w_fhist_next;
    logic [LANES*BITS-1:0]    w_word_flat;
    logic [BITS-1:0]          w_frame_word;
    logic                     w_boundary;
    logic                     w_frame_match;
    logic [LC_W-1:0]          w_match_inc;
    logic [UC_W-1:0]          w_miss_inc;
    logic [SW-1:0]            w_slip_inc;

    // Next-state histories: rise is the older bit, so it lands above fall.
    always_comb begin
        w_hist_next = '0;
        for (int l = 0; l < LANES; l++) begin
            w_hist_next[l] = {r_hist[l][HW-3:0], bit_rise[l], bit_fall[l]};
        end
        w_fhist_next = {r_fhist[HW-3:0], frame_rise, frame_fall};
    end

    // Word extraction from the next-state history at the current slip offset;
    // a larger slip selects older bits.
    always_comb begin
        w_word_flat = '0;
        for (int l = 0; l < LANES; l++) begin
            w_word_flat[l*BITS +: BITS] = BITS'(w_hist_next[l] >> r_slip);
        end
        w_frame_word = BITS'(w_fhist_next >> r_slip);
    end

    // Boundary detection, frame comparison and counter/slip increments.
    always_comb begin
        w_boundary    = (r_ph == PH_W'(PH_LAST));
        w_frame_match = (w_frame_word == FRAME_PATTERN);
        w_match_inc   = r_match_cnt + LC_W'(1);
        w_miss_inc    = r_miss_cnt + UC_W'(1);
        w_slip_inc    = (r_slip == SW'(BITS - 1)) ? '0 : r_slip + SW'(1);
    end

    // Bit histories shift every cycle; they are never cleared by resync.
    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist  <= '0;
            r_fhist <= '0;
        end else begin
            r_hist  <= w_hist_next;
            r_fhist <= w_fhist_next;
        end
    end

    // Free-running pair counter; the word boundary is its last value.
    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ph <= '0;
        end else if (w_boundary) begin
            r_ph <= '0;
        end else begin
            r_ph <= r_ph + PH_W'(1);
        end
    end

    // Alignment FSM with registered outputs; evaluated at word boundaries,
    // resync takes priority over a boundary in the same cycle.
    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_SEARCH;
            r_slip       <= '0;
            r_match_cnt  <= '0;
            r_miss_cnt   <= '0;
            r_locked     <= 1'b0;
            r_word_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_word_data  <= '0;
        end else begin
            r_word_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (resync) begin
                r_state     <= S_SEARCH;
                r_slip      <= '0;
                r_match_cnt <= '0;
                r_miss_cnt  <= '0;
                r_locked    <= 1'b0;
            end else if (w_boundary) begin
                case (r_state)
                    S_SEARCH: begin
                        if (w_frame_match) begin
                            if (w_match_inc == LC_W'(LOCK_CNT)) begin
                                // The locking boundary already carries a valid word.
                                r_state      <= S_LOCKED;
                                r_locked     <= 1'b1;
                                r_match_cnt  <= '0;
                                r_miss_cnt   <= '0;
                                r_word_data  <= w_word_flat;
                                r_word_valid <= 1'b1;
                            end else begin
                                r_match_cnt <= w_match_inc;
                            end
                        end else begin
                            r_match_cnt <= '0;
                            r_slip      <= w_slip_inc;
                            r_state     <= S_SETTLE;
                        end
                    end
                    S_SETTLE: begin
                        // The word straddling the slip change is discarded.
                        r_state <= S_SEARCH;
                    end
                    S_LOCKED: begin
                        r_word_data  <= w_word_flat;
                        r_word_valid <= 1'b1;
                        if (w_frame_match) begin
                            r_miss_cnt <= '0;
                        end else begin
                            r_frame_err <= 1'b1;
                            if (w_miss_inc == UC_W'(UNLOCK_CNT)) begin
                                // Lose lock but keep the slip: a glitch rather
                                // than a real phase move is the common case.
                                r_state     <= S_SEARCH;
                                r_locked    <= 1'b0;
                                r_match_cnt <= '0;
                                r_miss_cnt  <= '0;
                            end else begin
                                r_miss_cnt <= w_miss_inc;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_SEARCH;
                    end
                endcase
            end
        end
    end

    assign word_data  = r_word_data;
    assign word_valid = r_word_valid;
    assign locked     = r_locked;
    assign slip_pos   = r_slip;
    assign frame_err  = r_frame_err;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_adc_lane_deser.sv
`timescale 1ns/1ps
// tb_adc_lane_deser: directed stimulus with a tagged scoreboard. Each expected
// word carries the edge number (counted from reset release) at which it must
// appear; frame_err pulses are tracked the same way.
module tb_adc_lane_deser;

  localparam int LANES = 8;
  localparam int BITS  = 8;

  // ---------------- clock / reset ----------------
  logic dco_clk = 1'b0;
  logic rst_n;
  always #5 dco_clk = ~dco_clk;

  logic [LANES-1:0]      bit_rise;
  logic [LANES-1:0]      bit_fall;
  logic                  frame_rise;
  logic                  frame_fall;
  logic                  resync;
  logic [LANES*BITS-1:0] word_data;
  logic                  word_valid;
  logic                  locked;
  logic [2:0]            slip_pos;
  logic                  frame_err;
  logic [1:0]            dbg_state;

  adc_lane_deser #(
    .LANES(LANES), .BITS(BITS), .FRAME_PATTERN(8'hF0), .LOCK_CNT(4), .UNLOCK_CNT(2)
  ) dut (
    .dco_clk(dco_clk), .rst_n(rst_n),
    .bit_rise(bit_rise), .bit_fall(bit_fall),
    .frame_rise(frame_rise), .frame_fall(frame_fall),
    .resync(resync),
    .word_data(word_data), .word_valid(word_valid), .locked(locked),
    .slip_pos(slip_pos), .frame_err(frame_err), .dbg_state(dbg_state)
  );

  // Posedges seen since reset release; boundary m lands on edge 4*m.
  int edge_n = 0;
  always @(posedge dco_clk or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  // ---------------- stimulus configuration ----------------
  int foff = 0;             // serial offset: locks at slip = foff
  int corrupt_w[$];         // frame word indices replaced by 8'h0F

  int n_checks = 0;
  int n_fail   = 0;

  logic [79:0] exp_q[$];    // {edge tag[15:0], word_data[63:0]}
  logic [15:0] ferr_q[$];   // edge tags of expected frame_err pulses

  function automatic logic [7:0] data_word(int l, int w);
    logic [7:0] b;
    if (l == 0 || l == 2) b = 8'hA5;
    else                  b = 8'(l * 17) ^ 8'(w);
    return b;
  endfunction

  function automatic logic is_corrupt(int w);
    foreach (corrupt_w[i]) if (corrupt_w[i] == w) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] exp_word(int w);
    logic [63:0] v;
    v = '0;
    for (int l = 0; l < LANES; l++) v[l*8 +: 8] = data_word(l, w);
    return v;
  endfunction

  // ---------------- driver ----------------
  // Serial position q = 2*edge + k; word index and bit come from q + foff.
  always @(negedge dco_clk) begin : drv
    int q;
    int wi;
    int bi;
    logic [7:0] fw;
    logic [7:0] dw;
    for (int k = 0; k < 2; k++) begin
      q  = 2 * edge_n + k + foff;
      wi = q / 8;
      bi = 7 - (q % 8);
      fw = is_corrupt(wi) ? 8'h0F : 8'hF0;
      for (int l = 0; l < LANES; l++) begin
        dw = data_word(l, wi);
        if (k == 0) bit_rise[l] = dw[bi];
        else        bit_fall[l] = dw[bi];
      end
      if (k == 0) frame_rise = fw[bi];
      else        frame_fall = fw[bi];
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge dco_clk) begin : mon
    logic [79:0] e;
    logic [15:0] t;
    if (rst_n) begin
      if (word_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL word_valid_unexpected: strobe at edge %0d data=%h, required none", edge_n, word_data);
        end else begin
          e = exp_q.pop_front();
          if (e[79:64] != 16'(edge_n) || e[63:0] !== word_data) begin
            n_fail++;
            $display("FAIL word_check: got edge %0d data=%h, required edge %0d data=%h",
                     edge_n, word_data, e[79:64], e[63:0]);
          end
        end
      end
      if (frame_err) begin
        n_checks++;
        if (ferr_q.size() == 0) begin
          n_fail++;
          $display("FAIL frame_err_unexpected: pulse at edge %0d, required none", edge_n);
        end else begin
          t = ferr_q.pop_front();
          if (t != 16'(edge_n)) begin
            n_fail++;
            $display("FAIL frame_err_check: pulse at edge %0d, required edge %0d", edge_n, t);
          end
        end
      end
    end
  end

  // ---------------- helper tasks ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic wait_edge(input int n);
    int guard;
    guard = 0;
    do begin
      @(negedge dco_clk);
      guard++;
    end while (edge_n != n && guard < 500);
    if (edge_n != n) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_edge: edge count %0d, required %0d", edge_n, n);
    end
  endtask

  // Word of boundary m is frame word index m-1 and appears after edge 4*m.
  task automatic push_word(input int m);
    exp_q.push_back({16'(4 * m), exp_word(m - 1)});
  endtask

  task automatic chk_queues_empty(input string name);
    chk({name, "_words_left"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_ferr_left"}, 64'(ferr_q.size()), 64'd0);
  endtask

  task automatic release_reset();
    repeat (2) @(negedge dco_clk);
    rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    resync = 1'b0;
    rst_n  = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_word_data", word_data, 64'd0);
    chk("reset_word_valid", 64'(word_valid), 64'd0);
    chk("reset_locked", 64'(locked), 64'd0);
    chk("reset_slip_pos", 64'(slip_pos), 64'd0);
    chk("reset_frame_err", 64'(frame_err), 64'd0);
    chk("reset_state", 64'(dbg_state), 64'd0);

    // Aligned frame, one single-word corruption, then a two-word corruption.
    foff = 0;
    corrupt_w = '{9, 12, 13};
    for (int m = 4; m <= 14; m++) push_word(m);
    for (int m = 18; m <= 21; m++) push_word(m);
    ferr_q = '{16'd40, 16'd52, 16'd56};
    release_reset();

    wait_edge(15);
    chk("aligned_locked_before", 64'(locked), 64'd0);
    chk("aligned_slip_before", 64'(slip_pos), 64'd0);
    wait_edge(16);
    chk("aligned_locked", 64'(locked), 64'd1);
    chk("aligned_slip", 64'(slip_pos), 64'd0);
    chk("ddr_order_lane2", 64'(word_data[23:16]), 64'(8'b10100101));
    wait_edge(40);
    chk("single_miss_locked", 64'(locked), 64'd1);
    wait_edge(52);
    chk("first_of_two_locked", 64'(locked), 64'd1);
    wait_edge(56);
    chk("double_miss_unlocked", 64'(locked), 64'd0);
    chk("double_miss_slip_kept", 64'(slip_pos), 64'd0);
    wait_edge(71);
    chk("relock_not_yet", 64'(locked), 64'd0);
    wait_edge(72);
    chk("relock_locked", 64'(locked), 64'd1);
    wait_edge(86);
    chk_queues_empty("aligned");

    // Offset frame: lock expected at slip 3 after three slips.
    rst_n = 1'b0;
    foff = 3;
    corrupt_w.delete();
    for (int m = 10; m <= 12; m++) push_word(m);
    for (int m = 23; m <= 25; m++) push_word(m);
    release_reset();

    wait_edge(4);
    chk("offset_slip_1", 64'(slip_pos), 64'd1);
    wait_edge(8);
    chk("offset_slip_1_settle", 64'(slip_pos), 64'd1);
    wait_edge(12);
    chk("offset_slip_2", 64'(slip_pos), 64'd2);
    wait_edge(20);
    chk("offset_slip_3", 64'(slip_pos), 64'd3);
    wait_edge(39);
    chk("offset_locked_before", 64'(locked), 64'd0);
    wait_edge(40);
    chk("offset_locked", 64'(locked), 64'd1);
    chk("offset_slip_locked", 64'(slip_pos), 64'd3);
    chk("offset_lane0", 64'(word_data[7:0]), 64'(8'hA5));

    // Resync coinciding with a boundary edge (edge 52).
    wait_edge(51);
    resync = 1'b1;
    wait_edge(52);
    resync = 1'b0;
    chk("resync_locked", 64'(locked), 64'd0);
    chk("resync_slip", 64'(slip_pos), 64'd0);
    chk("resync_state", 64'(dbg_state), 64'd0);
    wait_edge(91);
    chk("resync_relock_before", 64'(locked), 64'd0);
    chk("resync_slip_3", 64'(slip_pos), 64'd3);
    wait_edge(92);
    chk("resync_relock", 64'(locked), 64'd1);
    wait_edge(101);
    chk_queues_empty("offset_resync");

    // Asynchronous reset mid-word (ph == 2 after edge 102), no clock edge.
    wait_edge(102);
    #1 rst_n = 1'b0;
    #1;
    chk("async_word_data", word_data, 64'd0);
    chk("async_word_valid", 64'(word_valid), 64'd0);
    chk("async_locked", 64'(locked), 64'd0);
    chk("async_slip_pos", 64'(slip_pos), 64'd0);
    chk("async_frame_err", 64'(frame_err), 64'd0);
    push_word(10);
    push_word(11);
    release_reset();
    wait_edge(39);
    chk("post_reset_locked_before", 64'(locked), 64'd0);
    wait_edge(40);
    chk("post_reset_locked", 64'(locked), 64'd1);
    chk("post_reset_slip", 64'(slip_pos), 64'd3);
    wait_edge(45);
    chk_queues_empty("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit as a backstop.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
